period_meter: RTL

Measures the period, and optionally the high time, of a slow, asynchronous periodic signal in fast-clock cycles. It is the receiving end of the clock-divider path: it confirms a divided clock (for example 4 Hz from 100 MHz) and reports each completed period through a valid/ready result port. It sits beside the divider in self-check and status logic.

---
 rtl/period_meter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the period (and optionally the high time) of a slow, asynchronous
// periodic signal in clk_in cycles. Each completed period is reported through
// a valid/ready result port. Losing the signal for TIMEOUT cycles sets a
// sticky timeout flag.
//
// Optional feature macro: PERIOD_METER_HIGH_TIME_EN
//   defined   : high_time reports the clk_in cycles sig_in was high within
//               the reported period.
//   undefined : no high-time counter is built; high_time is tied to 0.
//
// Parameters
//   WIDTH    counter / result width, TIMEOUT must fit in WIDTH bits
//   TIMEOUT  clk_in cycles without a rising edge before the signal is lost
//
// Ports
//   clk_in      in   fast clock, the only clock of the block
//   reset       in   synchronous, active-high reset
//   sig_in      in   measured signal, asynchronous to clk_in
//   meas_valid  out  a result is held on period/high_time
//   meas_ready  in   consumer accepts the result
//   period      out  clk_in cycles between two consecutive rising edges
//   high_time   out  clk_in cycles sig_in was high within that period
//   timeout     out  sticky: signal lost, cleared by the next result
//   overrun     out  one-cycle pulse: an unaccepted result was overwritten
//
// FSM states
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no reference edge yet; counter held at 0
//   ST_MEASURE | counting since the last rising edge; next edge gives result
// -----------------------------------------------------------------------------
module period_meter #(
  parameter int WIDTH   = 27,
  parameter int TIMEOUT = 50000000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             timeout,
  output logic             overrun
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] TimeoutCnt = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] One        = WIDTH'(1);

  state_e           state_q, state_d;
  logic             s1_q, s2_q, prev_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             rise;
  logic             latch_res;

  // Two-flop synchronizer followed by an edge-detect flop.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= sig_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise = s2_q & ~prev_q;

  // State and result registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    overrun_d = 1'b0;
    latch_res = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          cnt_d   = One;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // A rise on the timeout cycle still counts as a valid period.
        if (rise) begin
          latch_res = 1'b1;
          cnt_d     = One;
        end else if (cnt_q == TimeoutCnt) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A new result takes priority over the handshake completing in the
    // same cycle, so valid stays high and the fresh data is presented.
    if (latch_res) begin
      period_d  = cnt_q;
      valid_d   = 1'b1;
      timeout_d = 1'b0;
      overrun_d = valid_q & ~meas_ready;
    end else if (valid_q && meas_ready) begin
      valid_d = 1'b0;
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] high_q, high_d;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  // The rise cycle itself is the first high cycle, hence the load of 1.
  always_comb begin
    hcnt_d = hcnt_q;
    high_d = high_q;
    if (state_q == ST_IDLE) begin
      hcnt_d = rise ? One : '0;
    end else if (rise) begin
      hcnt_d = One;
    end else if (s2_q) begin
      hcnt_d = hcnt_q + One;
    end
    if (latch_res) begin
      high_d = hcnt_q;
    end
  end

  assign high_time = high_q;
`else
  assign high_time = '0;
`endif

  assign meas_valid = valid_q;
  assign period     = period_q;
  assign timeout    = timeout_q;
  assign overrun    = overrun_q;

endmodule
